// File: rtl/sseg_frame_decoder_if.sv
// Seven-segment snoop bus: anode/segment lines in, reassembled frame out.
interface sseg_frame_decoder_if #(
    parameter int unsigned N_DIGITS = 4
);
    logic [N_DIGITS-1:0]   an;
    logic [6:0]            sseg;
    logic [4*N_DIGITS-1:0] value;
    logic                  frame_valid;
    logic [N_DIGITS-1:0]   err_mask;

    // Display-side driver of the lines being snooped
    modport master (
        output an,
        output sseg,
        input  value,
        input  frame_valid,
        input  err_mask
    );

    // Decoder side
    modport slave (
        input  an,
        input  sseg,
        output value,
        output frame_valid,
        output err_mask
    );
endinterface

// File: rtl/sseg_frame_decoder.sv
// Snoops a multiplexed active-low seven-segment bus and reassembles one full
// scan into a hex value word, flagging digits that were not valid glyphs.
module sseg_frame_decoder #(
    parameter int unsigned N_DIGITS      = 4,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input logic                 clk,
    input logic                 rst,
    sseg_frame_decoder_if.slave bus
);

    localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned IdxW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSettle, StHold} state_e;

    state_e                state_q, state_d;
    logic [N_DIGITS-1:0]   an_q;
    logic [6:0]            sseg_q;
    logic [CntW-1:0]       cnt_q;
    logic [N_DIGITS-1:0]   mask_q, mask_d;
    logic [4*N_DIGITS-1:0] shadow_val_q;
    logic [N_DIGITS-1:0]   shadow_err_q;
    logic [4*N_DIGITS-1:0] value_q;
    logic [N_DIGITS-1:0]   err_q;
    logic                  fv_q;

    logic                  an_valid;
    logic [IdxW-1:0]       cur_idx;
    int unsigned           zeros;
    logic                  changed;
    logic                  cnt_done;
    logic                  mask_full;
    logic [4:0]            glyph;
    logic                  load_pair;
    logic                  cnt_inc;
    logic                  sample;

    // Returns {not_a_glyph, nibble}; unknown patterns decode to 0 with the error flag set
    function automatic logic [4:0] decode_glyph(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b0000001: r = 5'h00;
            7'b1001111: r = 5'h01;
            7'b0010010: r = 5'h02;
            7'b0000110: r = 5'h03;
            7'b1001100: r = 5'h04;
            7'b0100100: r = 5'h05;
            7'b0100000: r = 5'h06;
            7'b0001111: r = 5'h07;
            7'b0000000: r = 5'h08;
            7'b0000100: r = 5'h09;
            7'b0001000: r = 5'h0A;
            7'b1100000: r = 5'h0B;
            7'b0110001: r = 5'h0C;
            7'b1000010: r = 5'h0D;
            7'b0110000: r = 5'h0E;
            7'b0111000: r = 5'h0F;
            default:    r = 5'h10;
        endcase
        return r;
    endfunction

    // Anode validity on the live bus; digit index from the registered copy
    always_comb begin
        zeros   = 0;
        cur_idx = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (!bus.an[i]) zeros = zeros + 1;
            if (!an_q[i]) cur_idx = IdxW'(i);
        end
        an_valid = (zeros == 1);
    end

    assign changed   = (bus.an != an_q) || (bus.sseg != sseg_q);
    assign cnt_done  = (cnt_q == CntLast);
    assign mask_full = &mask_q;
    assign glyph     = decode_glyph(sseg_q);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (an_valid) state_d = StSettle;
            end
            StSettle: begin
                if (changed)       state_d = an_valid ? StSettle : StIdle;
                else if (cnt_done) state_d = StHold;
            end
            StHold: begin
                if (changed) state_d = an_valid ? StSettle : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM control strobes
    always_comb begin
        load_pair = 1'b0;
        cnt_inc   = 1'b0;
        sample    = 1'b0;
        case (state_q)
            StIdle: load_pair = an_valid;
            StSettle: begin
                if (changed)       load_pair = an_valid;
                else if (cnt_done) sample    = 1'b1;
                else               cnt_inc   = 1'b1;
            end
            StHold: load_pair = changed && an_valid;
            default: ;
        endcase
    end

    // Capture mask: cleared the cycle a full frame is published
    always_comb begin
        mask_d = mask_full ? '0 : mask_q;
        if (sample) mask_d[cur_idx] = 1'b1;
    end

    // Dwell tracking, shadow frame and published outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            an_q         <= '1;
            sseg_q       <= '1;
            cnt_q        <= '0;
            mask_q       <= '0;
            shadow_val_q <= '0;
            shadow_err_q <= '0;
            value_q      <= '0;
            err_q        <= '0;
            fv_q         <= 1'b0;
        end else begin
            if (load_pair) begin
                an_q   <= bus.an;
                sseg_q <= bus.sseg;
                cnt_q  <= '0;
            end else if (cnt_inc) begin
                cnt_q <= cnt_q + CntW'(1);
            end
            if (sample) begin
                shadow_val_q[{cur_idx, 2'b00} +: 4] <= glyph[3:0];
                shadow_err_q[cur_idx]               <= glyph[4];
            end
            mask_q <= mask_d;
            fv_q   <= mask_full;
            if (mask_full) begin
                value_q <= shadow_val_q;
                err_q   <= shadow_err_q;
            end
        end
    end

    assign bus.value       = value_q;
    assign bus.err_mask    = err_q;
    assign bus.frame_valid = fv_q;

endmodule
